lsu_smrd_mem_sequencer: RTL

Sits directly downstream of the LSU read-stage router, on the scalar (SMRD) path. Takes one scalar load per issue: the SGPR base, the offset, the dword read-enable mask and the destination register. Issues the dwords as sequential single-outstanding memory read requests and assembles the returned data. Writes the result back to the SGPR file in one cycle.

---
 rtl/lsu_smrd_mem_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/lsu_smrd_mem_sequencer.sv
// Scalar (SMRD) load sequencer: one load per issue, 1/2/4 dwords fetched as sequential single-outstanding reads, one-cycle SGPR writeback.
// Latency: issue to first request 1 cycle; issue to out_done count+1 cycles with zero-wait acks.
// Backpressure: each request is held until in_mem_ack; issues while busy are dropped silently, so upstream must wait for out_busy=0.
//
// Ports:
//   clk, rst (async active-low)
//   in_issue_valid/in_rd_en/in_lddst_addr/in_base_addr/in_offset/in_wfid : issue from the router stage
//   out_busy                                                             : high whenever not IDLE
//   out_mem_rd_req/out_mem_addr, in_mem_ack/in_mem_rd_data               : memory read handshake
//   out_sgpr_wr_en/_addr/_data, out_wfid, out_done                       : one-cycle writeback
//   out_err                                                              : pulse after a rejected issue
module lsu_smrd_mem_sequencer #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_issue_valid,
  input  logic [3:0]            in_rd_en,
  input  logic [11:0]           in_lddst_addr,
  input  logic [ADDR_WIDTH-1:0] in_base_addr,
  input  logic [ADDR_WIDTH-1:0] in_offset,
  input  logic [5:0]            in_wfid,
  output logic                  out_busy,
  output logic                  out_mem_rd_req,
  output logic [ADDR_WIDTH-1:0] out_mem_addr,
  input  logic                  in_mem_ack,
  input  logic [31:0]           in_mem_rd_data,
  output logic [3:0]            out_sgpr_wr_en,
  output logic [8:0]            out_sgpr_wr_addr,
  output logic [127:0]          out_sgpr_wr_data,
  output logic [5:0]            out_wfid,
  output logic                  out_done,
  output logic                  out_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WB   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] start_q, start_d;
  logic [3:0]            mask_q,  mask_d;
  logic [1:0]            last_q,  last_d;   // index of the final dword (count-1)
  logic [1:0]            idx_q,   idx_d;
  logic [8:0]            dest_q,  dest_d;
  logic [5:0]            wfid_q,  wfid_d;
  logic [127:0]          buf_q,   buf_d;
  logic                  err_q,   err_d;

  logic [ADDR_WIDTH-1:0] issue_start;
  logic                  mask_legal;
  logic [1:0]            mask_last;

  // Destination bits above the SGPR range carry no meaning on this path.
  logic                  unused_dest_hi;
  assign unused_dest_hi = ^in_lddst_addr[11:9];

  assign issue_start = in_base_addr + in_offset;

  always_comb begin
    mask_legal = 1'b1;
    mask_last  = 2'd0;
    case (in_rd_en)
      4'b0001: mask_last = 2'd0;
      4'b0011: mask_last = 2'd1;
      4'b1111: mask_last = 2'd3;
      default: mask_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    mask_d  = mask_q;
    last_d  = last_q;
    idx_d   = idx_q;
    dest_d  = dest_q;
    wfid_d  = wfid_q;
    buf_d   = buf_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_issue_valid) begin
          if (mask_legal && (issue_start[1:0] == 2'b00)) begin
            start_d = issue_start;
            mask_d  = in_rd_en;
            last_d  = mask_last;
            idx_d   = 2'd0;
            dest_d  = in_lddst_addr[8:0];
            wfid_d  = in_wfid;
            buf_d   = '0;
            state_d = S_REQ;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (in_mem_ack) begin
          buf_d[32*idx_q +: 32] = in_mem_rd_data;
          if (idx_q == last_q) begin
            state_d = S_WB;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      start_q <= '0;
      mask_q  <= '0;
      last_q  <= '0;
      idx_q   <= '0;
      dest_q  <= '0;
      wfid_q  <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      mask_q  <= mask_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      dest_q  <= dest_d;
      wfid_q  <= wfid_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode straight from state so an async reset clears them immediately.
  always_comb begin
    out_busy         = (state_q != S_IDLE);
    out_mem_rd_req   = (state_q == S_REQ);
    out_mem_addr     = '0;
    out_sgpr_wr_en   = '0;
    out_sgpr_wr_addr = '0;
    out_sgpr_wr_data = '0;
    out_wfid         = '0;
    out_done         = 1'b0;
    out_err          = err_q;
    if (state_q == S_REQ) begin
      // Address wraps modulo 2^ADDR_WIDTH by truncation of the sum.
      out_mem_addr = start_q + {{(ADDR_WIDTH-4){1'b0}}, idx_q, 2'b00};
    end
    if (state_q == S_WB) begin
      out_sgpr_wr_en   = mask_q;
      out_sgpr_wr_addr = dest_q;
      out_sgpr_wr_data = buf_q;
      out_wfid         = wfid_q;
      out_done         = 1'b1;
    end
  end

endmodule
